// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the rv32 data-memory responder.
// Latency: none (declarations only).
// Backpressure: none of its own; used by the responder's gnt/rvalid handshake.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

package rv32_mem_pkg;

    // Access size as driven on rv32_d_size; 2'b11 has no enum member and is a fault.
    typedef enum logic [1:0] {
        RV32_MEM_B = 2'b00,
        RV32_MEM_H = 2'b01,
        RV32_MEM_W = 2'b10
    } rv32_mem_size_e;

    localparam logic [1:0] RV32_MEM_ILLEGAL = 2'b11;

    // Responder transaction state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } rv32_mem_state_e;

    localparam int RV32_MEM_DEPTH_WORDS = 1024;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] rv32_mem_byte_en(input logic [1:0] size,
                                                    input logic [1:0] offset);
        logic [3:0] en;
        en = 4'b0000;
        case (size)
            RV32_MEM_B: en = 4'b0001 << offset;
            RV32_MEM_H: en = offset[1] ? 4'b1100 : 4'b0011;
            RV32_MEM_W: en = 4'b1111;
            default:    en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load lane select plus sign/zero extension of a fetched 32-bit word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_load_align
    import rv32_mem_pkg::*;
(
    input  logic [`XPR_LEN-1:0] word,
    input  logic [1:0]          offset,
    input  logic [1:0]          size,
    input  logic                zero_ext,
    output logic [`XPR_LEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half and extend it; word loads pass straight through.
    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        data   = '0;
        case (size)
            RV32_MEM_B: data = zero_ext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            RV32_MEM_H: data = zero_ext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            RV32_MEM_W: data = word;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Single-outstanding data-memory responder with byte-lane stores and fault checking.
// Latency: WAIT_STATES+1 cycles from accept edge to a one-cycle rv32_d_rvalid pulse.
// Backpressure: rv32_d_gnt only in IDLE; requests outside IDLE are ignored, not queued.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = RV32_MEM_DEPTH_WORDS,
    parameter int WAIT_STATES = 1
)(
    input  logic                rv32_clk,
    input  logic                rv32_rst,
    input  logic                rv32_d_req,
    output logic                rv32_d_gnt,
    input  logic [`XPR_LEN-1:0] rv32_d_addr,
    input  logic                rv32_wr_en,
    input  logic [1:0]          rv32_d_size,
    input  logic                rv32_d_unsigned,
    input  logic [`XPR_LEN-1:0] rv32_o_data,
    output logic                rv32_d_rvalid,
    output logic [`XPR_LEN-1:0] rv32_d_data,
    output logic                rv32_d_err
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  CNT_INIT    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    rv32_mem_state_e state, next_state;
    logic [2:0]      cnt, next_cnt;
    logic            accept;
    logic            enter_resp;

    // Request captured at accept; valid for the whole of WAIT and RESP.
    logic [`XPR_LEN-1:0] addr_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [`XPR_LEN-1:0] wdata_q;
    logic                fault_q;

    // The transaction as seen on the edge entering RESP: with zero wait states
    // that edge is the accept edge, so the live inputs are used instead of the
    // (not yet loaded) capture registers.
    logic [`XPR_LEN-1:0] cur_addr;
    logic                cur_wr;
    logic [1:0]          cur_size;
    logic [`XPR_LEN-1:0] cur_wdata;
    logic                cur_fault;
    logic [IDX_W-1:0]    word_idx;
    logic [3:0]          byte_en;
    logic [31:0]         wdata_lanes;

    logic [`XPR_LEN-1:0] mem [DEPTH_WORDS];
    logic [`XPR_LEN-1:0] rd_word;
    logic [`XPR_LEN-1:0] load_data;

    assign accept = rv32_d_req && rv32_d_gnt && !rv32_rst;

    // State and wait counter; reset drops any transaction in flight.
    always_ff @(posedge rv32_clk or posedge rv32_rst) begin
        if (rv32_rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state, counter load/decrement and grant.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        rv32_d_gnt = (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 3'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP) && !rv32_rst;

    // Capture the accepted request.
    always_ff @(posedge rv32_clk or posedge rv32_rst) begin
        if (rv32_rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= rv32_d_addr;
            wr_q    <= rv32_wr_en;
            size_q  <= rv32_d_size;
            uns_q   <= rv32_d_unsigned;
            wdata_q <= rv32_o_data;
        end
    end

    // Select the transaction source and classify faults.
    always_comb begin
        cur_addr  = (state == IDLE) ? rv32_d_addr     : addr_q;
        cur_wr    = (state == IDLE) ? rv32_wr_en      : wr_q;
        cur_size  = (state == IDLE) ? rv32_d_size     : size_q;
        cur_wdata = (state == IDLE) ? rv32_o_data     : wdata_q;
        cur_fault = 1'b0;
        if (cur_size == RV32_MEM_ILLEGAL)                       cur_fault = 1'b1;
        if (cur_size == RV32_MEM_H && cur_addr[0])              cur_fault = 1'b1;
        if (cur_size == RV32_MEM_W && cur_addr[1:0] != 2'b00)   cur_fault = 1'b1;
        if ({2'b00, cur_addr[31:2]} >= DEPTH_LIMIT)             cur_fault = 1'b1;
        word_idx = cur_addr[IDX_W+1:2];
        byte_en  = rv32_mem_byte_en(cur_size, cur_addr[1:0]);
        case (cur_size)
            RV32_MEM_B: wdata_lanes = {4{cur_wdata[7:0]}};
            RV32_MEM_H: wdata_lanes = {2{cur_wdata[15:0]}};
            default:    wdata_lanes = cur_wdata;
        endcase
    end

    // Fault flag for the response, latched on the edge entering RESP.
    always_ff @(posedge rv32_clk or posedge rv32_rst) begin
        if (rv32_rst) begin
            fault_q <= 1'b0;
        end else if (enter_resp) begin
            fault_q <= cur_fault;
        end
    end

    // Backing store: commit stores / read loads on the edge entering RESP; never cleared.
    always_ff @(posedge rv32_clk) begin
        if (enter_resp && !cur_fault) begin
            if (cur_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                    end
                end
            end else begin
                rd_word <= mem[word_idx];
            end
        end
    end

    rv32_load_align u_load_align (
        .word     (rd_word),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .zero_ext (uns_q),
        .data     (load_data)
    );

    // Response outputs are all qualified by RESP so they clear the instant reset hits.
    always_comb begin
        rv32_d_rvalid = (state == RESP);
        rv32_d_err    = (state == RESP) && fault_q;
        rv32_d_data   = ((state == RESP) && !fault_q && !wr_q) ? load_data : '0;
    end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 3, 0) driven from vector tables
// and hand-written sequences for reset-abort and back-to-back request corners.
// Expected values are hand-computed constants.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module tb_rv32_dmem_responder;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [31:0] addr  [3];
    logic [2:0]  wr;
    logic [1:0]  size  [3];
    logic [2:0]  uns;
    logic [31:0] wdata [3];
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    rv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .rv32_clk(clk), .rv32_rst(rst[0]), .rv32_d_req(req[0]), .rv32_d_gnt(gnt[0]),
        .rv32_d_addr(addr[0]), .rv32_wr_en(wr[0]), .rv32_d_size(size[0]),
        .rv32_d_unsigned(uns[0]), .rv32_o_data(wdata[0]), .rv32_d_rvalid(rvalid[0]),
        .rv32_d_data(rdata[0]), .rv32_d_err(err[0])
    );

    rv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .rv32_clk(clk), .rv32_rst(rst[1]), .rv32_d_req(req[1]), .rv32_d_gnt(gnt[1]),
        .rv32_d_addr(addr[1]), .rv32_wr_en(wr[1]), .rv32_d_size(size[1]),
        .rv32_d_unsigned(uns[1]), .rv32_o_data(wdata[1]), .rv32_d_rvalid(rvalid[1]),
        .rv32_d_data(rdata[1]), .rv32_d_err(err[1])
    );

    rv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .rv32_clk(clk), .rv32_rst(rst[2]), .rv32_d_req(req[2]), .rv32_d_gnt(gnt[2]),
        .rv32_d_addr(addr[2]), .rv32_wr_en(wr[2]), .rv32_d_size(size[2]),
        .rv32_d_unsigned(uns[2]), .rv32_o_data(wdata[2]), .rv32_d_rvalid(rvalid[2]),
        .rv32_d_data(rdata[2]), .rv32_d_err(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access on instance i: wait for grant, measure accept-to-rvalid latency,
    // capture the response, then sample one cycle later to see the pulse end.
    task automatic access(input int i, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d, output logic e, output int lat,
                          output logic rv_after, output logic [31:0] d_after);
        int n;
        @(negedge clk);
        req[i] = 1'b1; wr[i] = w; size[i] = sz; uns[i] = u; addr[i] = a; wdata[i] = wd;
        n = 0;
        while (!gnt[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req[i] = 1'b0;
        lat = 1;
        while (!rvalid[i] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = rdata[i];
        e = err[i];
        @(posedge clk);
        #1;
        rv_after = rvalid[i];
        d_after  = rdata[i] | {31'b0, err[i]};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d_after;
        logic        e, rv_after;
        int          lat, acc, rv_seen;

        rst = 3'b111; req = '0; wr = '0; uns = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; size[i] = 2'b10; wdata[i] = '0;
        end

        // Reset state on all three instances.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_gnt%0d", i),    {31'b0, gnt[i]},    32'd1);
            chk($sformatf("rst_rvalid%0d", i), {31'b0, rvalid[i]}, 32'd0);
            chk($sformatf("rst_err%0d", i),    {31'b0, err[i]},    32'd0);
            chk($sformatf("rst_data%0d", i),   rdata[i],           32'd0);
        end
        rst = 3'b000;

        // Vector table for WAIT_STATES = 1.
        vecs.push_back('{"sw10",   1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{"lw10",   1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sb11",   1'b1, 2'b00, 1'b0, 32'h11,   32'h00000080, 32'h00000000, 1'b0});
        vecs.push_back('{"lb11",   1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{"lbu11",  1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{"lw10b",  1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{"lh12",   1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0});
        vecs.push_back('{"lhu12",  1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h0000DEAD, 1'b0});
        vecs.push_back('{"lb10",   1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{"lbu13",  1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{"lwu10",  1'b0, 2'b10, 1'b1, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{"lh13",   1'b0, 2'b01, 1'b0, 32'h13,   32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{"sw12",   1'b1, 2'b10, 1'b0, 32'h12,   32'h11111111, 32'h00000000, 1'b1});
        vecs.push_back('{"lw10c",  1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{"sz11",   1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{"lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{"swffc",  1'b1, 2'b10, 1'b0, 32'hFFC,  32'h0BADF00D, 32'h00000000, 1'b0});
        vecs.push_back('{"lwffc",  1'b0, 2'b10, 1'b0, 32'hFFC,  32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{"sw14",   1'b1, 2'b10, 1'b0, 32'h14,   32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{"sh16",   1'b1, 2'b01, 1'b0, 32'h16,   32'h1234ABCD, 32'h00000000, 1'b0});
        vecs.push_back('{"lw14",   1'b0, 2'b10, 1'b0, 32'h14,   32'h0,        32'hABCD0000, 1'b0});

        foreach (vecs[k]) begin
            access(0, vecs[k].wr, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                   d, e, lat, rv_after, d_after);
            chk({vecs[k].name, "_data"}, d, vecs[k].exp_data);
            chk({vecs[k].name, "_err"},  {31'b0, e}, {31'b0, vecs[k].exp_err});
            chk({vecs[k].name, "_lat"},  32'(lat), 32'd2);
            chk({vecs[k].name, "_after"}, {31'b0, rv_after} | d_after, 32'd0);
        end

        // WAIT_STATES = 3: reset one cycle after accept aborts a store.
        access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, d, e, lat, rv_after, d_after);
        chk("ws3_sw_lat", 32'(lat), 32'd4);
        chk("ws3_sw_err", {31'b0, e}, 32'd0);
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'h20; wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        chk("ws3_in_wait_gnt", {31'b0, gnt[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        req[1] = 1'b1;
        #1;
        chk("ws3_rst_gnt", {31'b0, gnt[1]}, 32'd1);
        chk("ws3_rst_rvalid", {31'b0, rvalid[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        req[1] = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid[1]) rv_seen++;
        end
        chk("ws3_no_rvalid", 32'(rv_seen), 32'd0);
        access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, lat, rv_after, d_after);
        chk("ws3_lw20_data", d, 32'hCAFEF00D);
        chk("ws3_lw20_lat", 32'(lat), 32'd4);

        // WAIT_STATES = 0: request held high accepts every second cycle.
        access(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h55AA55AA, d, e, lat, rv_after, d_after);
        chk("ws0_sw_lat", 32'(lat), 32'd1);
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'b10; addr[2] = 32'h40; wdata[2] = 32'h0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ws0_gnt_c%0d", k),    {31'b0, gnt[2]},    (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("ws0_rvalid_c%0d", k), {31'b0, rvalid[2]}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (gnt[2] && req[2]) acc++;
            if (rvalid[2]) begin
                chk($sformatf("ws0_data_c%0d", k), rdata[2], 32'h55AA55AA);
                wr[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hFFFFFFFF; size[2] = 2'b00;
            end else begin
                wr[2] = 1'b0; addr[2] = 32'h40; wdata[2] = 32'h0; size[2] = 2'b10;
            end
            @(negedge clk);
        end
        req[2] = 1'b0;
        chk("ws0_accepts", 32'(acc), 32'd3);
        access(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat, rv_after, d_after);
        chk("ws0_lw40_data", d, 32'h55AA55AA);
        chk("ws0_lw40_lat", 32'(lat), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
